// File: rtl/seq_unsigned_multiply.sv
// seq_unsigned_multiply: shift-add unsigned multiplier retiring BPC multiplier bits per cycle behind valid/ready handshakes.
module seq_unsigned_multiply #(
    parameter int A_WIDTH = 5,
    parameter int B_WIDTH = 5,
    parameter int BPC     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A_WIDTH-1:0]         dataa,
    input  logic [B_WIDTH-1:0]         datab,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [A_WIDTH+B_WIDTH-1:0] dataout,
    output logic                       busy
);
    localparam int STEPS = (B_WIDTH + BPC - 1) / BPC;
    localparam int PW    = STEPS * BPC;
    localparam int P     = A_WIDTH + B_WIDTH;
    localparam int W     = A_WIDTH + PW;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] mcand_q, mcand_d;
    logic [PW-1:0]      mplier_q, mplier_d;
    logic [P-1:0]       acc_q, acc_d, pp;
    logic [SW-1:0]      step_q, step_d;
    logic               out_valid_q, out_valid_d, busy_q, busy_d;
    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign dataout   = acc_q;
    // Every partial sum is bounded by the final product, so truncating to P bits is exact.
    assign pp = P'((W'(mcand_q) * W'(mplier_q[BPC-1:0])) << (step_q * BPC));
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        step_d   = step_q;
        if (state_q == BUSY) begin
            acc_d    = acc_q + pp;
            mplier_d = mplier_q >> BPC;
            step_d   = step_q + SW'(1);
            state_d  = (step_q == SW'(STEPS - 1)) ? DONE : BUSY;
        end else if (in_valid && in_ready) begin
            mcand_d  = dataa;
            mplier_d = PW'(datab);
            acc_d    = '0;
            step_d   = '0;
            state_d  = BUSY;
        end else if (state_q == DONE && out_ready) begin
            state_d  = IDLE;
        end
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == BUSY);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            step_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end
endmodule

// File: tb/tb_seq_unsigned_multiply.sv
// tb_seq_unsigned_multiply: checks a default instance and an 8x5/BPC=2 instance against plain a*b with fixed latency.
module tb_seq_unsigned_multiply;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic iv0, ir0, ov0, or0, bz0;
    logic [4:0] a0, b0;
    logic [9:0] d0;
    logic iv1, ir1, ov1, or1, bz1;
    logic [7:0] a1;
    logic [4:0] b1;
    logic [12:0] d1;
    int tests = 0;
    int fails = 0;
    typedef struct {int a; int b; int p; int lat;} vec_t;
    vec_t vecs[5];
    seq_unsigned_multiply u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .dataa(a0), .datab(b0),
        .out_valid(ov0), .out_ready(or0), .dataout(d0), .busy(bz0)
    );
    seq_unsigned_multiply #(.A_WIDTH(8), .B_WIDTH(5), .BPC(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .dataa(a1), .datab(b1),
        .out_valid(ov1), .out_ready(or1), .dataout(d1), .busy(bz1)
    );
    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    task automatic op0(input int a, input int b, output int p, output int lat, output int bc);
        int w = 0;
        while (!ir0 && w < 50) begin @(posedge clk); #1; w++; end
        iv0 = 1'b1; a0 = a[4:0]; b0 = b[4:0];
        @(posedge clk); #1;
        iv0 = 1'b0; a0 = 5'($urandom); b0 = 5'($urandom);
        lat = 0; bc = 0;
        while (!ov0 && lat < 50) begin bc += int'(bz0); @(posedge clk); #1; lat++; end
        p = int'(d0);
    endtask
    task automatic op1(input int a, input int b, output int p, output int lat);
        int w = 0;
        while (!ir1 && w < 50) begin @(posedge clk); #1; w++; end
        iv1 = 1'b1; a1 = a[7:0]; b1 = b[4:0];
        @(posedge clk); #1;
        iv1 = 1'b0; a1 = 8'($urandom); b1 = 5'($urandom);
        lat = 0;
        while (!ov1 && lat < 50) begin @(posedge clk); #1; lat++; end
        p = int'(d1);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int p, lat, bc, seen, a, b, k;
        vecs[0] = '{31, 31, 961, 5};
        vecs[1] = '{0, 17, 0, 5};
        vecs[2] = '{19, 1, 19, 5};
        vecs[3] = '{0, 0, 0, 5};
        vecs[4] = '{21, 13, 273, 5};
        iv0 = 0; or0 = 1; a0 = 0; b0 = 0;
        iv1 = 0; or1 = 1; a1 = 0; b1 = 0;
        #1;
        check("reset_in_ready", ir0, 1);
        check("reset_out_valid", ov0, 0);
        check("reset_busy", bz0, 0);
        check("reset_dataout", d0, 0);
        check("reset_dataout_p", d1, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            op0(vecs[i].a, vecs[i].b, p, lat, bc);
            check($sformatf("prod_%0dx%0d", vecs[i].a, vecs[i].b), p, vecs[i].p);
            check($sformatf("lat_%0dx%0d", vecs[i].a, vecs[i].b), lat, vecs[i].lat);
            check($sformatf("busy_%0dx%0d", vecs[i].a, vecs[i].b), bc, 5);
            @(posedge clk); #1;
            check("idle_after_handoff", {ov0, bz0, ir0}, 3'b001);
        end
        or0 = 0;
        op0(7, 9, p, lat, bc);
        check("bp_prod", p, 63);
        check("bp_lat", lat, 5);
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_hold_data", d0, 63);
            check("bp_hold_valid", ov0, 1);
            check("bp_in_ready", ir0, 0);
        end
        or0 = 1; #1;
        check("bp_release_ready", ir0, 1);
        @(posedge clk); #1;
        check("bp_idle", {ov0, bz0, ir0}, 3'b001);
        op0(3, 5, p, lat, bc);
        check("b2b_first", p, 15);
        check("b2b_ready_in_done", ir0, 1);
        op0(6, 7, p, lat, bc);
        check("b2b_second", p, 42);
        check("b2b_lat", lat, 5);
        check("b2b_busy", bc, 5);
        @(posedge clk); #1;
        iv0 = 1; a0 = 25; b0 = 25;
        @(posedge clk); #1;
        iv0 = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0; #1;
        check("rst_out_valid", ov0, 0);
        check("rst_dataout", d0, 0);
        check("rst_busy", bz0, 0);
        check("rst_in_ready", ir0, 1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ov0 || d0 == 10'd625) seen++;
        end
        check("rst_no_stale_output", seen, 0);
        op0(2, 3, p, lat, bc);
        check("post_rst_prod", p, 6);
        check("post_rst_lat", lat, 5);
        for (int i = 0; i < 30; i++) begin
            a = $urandom_range(0, 31); b = $urandom_range(0, 31);
            op0(a, b, p, lat, bc);
            check($sformatf("rnd0_%0dx%0d", a, b), p, a * b);
            check("rnd0_lat", lat, 5);
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end
        op1(255, 31, p, lat);
        check("p_prod_255x31", p, 7905);
        check("p_lat_255x31", lat, 3);
        for (int i = 0; i < 100; i++) begin
            a = $urandom_range(0, 255); b = $urandom_range(0, 31);
            op1(a, b, p, lat);
            check($sformatf("rnd1_%0dx%0d", a, b), p, a * b);
            check("rnd1_lat", lat, 3);
            k = $urandom_range(0, 3);
            if (k > 0) begin
                or1 = 0;
                repeat (k) begin
                    @(posedge clk); #1;
                    check("rnd1_hold", {ov1, d1}, {1'b1, 13'(a * b)});
                end
                or1 = 1;
            end
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
